mips_cpu_mult_div: RTL
======================

MIPS_CPU_MULT_DIV -- requirements
Module: mips_cpu_mult_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width.
REQ-002 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port start  input  1: op valid this cycle.
REQ-005 SHALL have port op  input  3: 011 MULT, 001 MULTU, 010 DIV, 000 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO.
REQ-006 SHALL have port a  input  WIDTH: rs operand (multiplicand, dividend, or MTHI/MTLO source).
REQ-007 SHALL have port b  input  WIDTH: rt operand (multiplier or divisor).
REQ-008 SHALL have port busy  output  1: MULT/DIV in progress; the CPU stalls while high.
REQ-009 SHALL have port done  output  1: one-cycle pulse; HI/LO hold the new result.
REQ-010 SHALL have port result  output  WIDTH: combinational; HI when op=110, LO when op=111, else 0.
REQ-011 SHALL have port hi  output  WIDTH: HI register.
REQ-012 SHALL have port lo  output  WIDTH: LO register.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and FIX.
REQ-014 SHALL accept start only in IDLE and ignore start in RUN and FIX (no queueing).
REQ-015 MTHI/MTLO with start in IDLE SHALL write a to HI/LO at that edge, with no busy and no done.
REQ-016 MFHI/MFLO SHALL need no start and no state change; result SHALL reflect current HI/LO.
REQ-017 MULT/MULTU/DIV/DIVU accepted at edge N SHALL enter RUN with iteration count 0 and busy=1.
REQ-018 RUN SHALL do one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
REQ-019 RUN SHALL last exactly WIDTH cycles and then go to FIX.
REQ-020 FIX SHALL last one cycle and then go to IDLE.
REQ-021 At the FIX->IDLE edge (N+WIDTH+1), HI/LO SHALL be written, busy SHALL fall, and done SHALL be high for the following cycle only.
REQ-022 Operands SHALL be captured at accept; a and b changing during RUN SHALL have no effect.
REQ-023 Signed ops SHALL operate on magnitudes, with sign correction applied in FIX.
REQ-024 MULT/MULTU SHALL give {HI,LO} = full 2*WIDTH-bit product (two's complement for MULT).
REQ-025 DIV/DIVU SHALL give LO=quotient and HI=remainder, truncating toward zero.
REQ-026 For DIV, quotient sign SHALL be sign(a) XOR sign(b), and remainder sign SHALL be sign(a).
REQ-027 Divide by zero (b=0), signed or unsigned, SHALL give LO=all-ones and HI=a.
REQ-028 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-029 When not busy, HI/LO SHALL change only via MTHI, MTLO or a completing MULT/DIV.

Reset
REQ-030 Reset SHALL set state=IDLE, hi=0, lo=0, busy=0, done=0 and clear the iteration counter and datapath registers.
REQ-031 Reset SHALL take priority over start and over an operation in progress, aborting it with no HI/LO write.
REQ-032 The first start SHALL be accepted in the cycle after reset deasserts.

Structure
REQ-033 The op encoding (8 codes) and the FSM state type SHALL be defined in the shared package mips_cpu_pkg, also used by the ALU control decoder.
REQ-034 The counter width, $clog2(WIDTH)+1, SHALL be a localparam.
REQ-035 The multiply and divide datapaths SHALL share one 2*WIDTH accumulator and one adder/subtractor.
REQ-036 No sub-module SHALL be used; the block is a single module.

Verification
REQ-037 MULTU a=0xFFFFFFFF b=0xFFFFFFFF SHALL give busy for 33 cycles, then done with HI=0xFFFFFFFE and LO=0x00000001.
REQ-038 MULT a=0xFFFFFFFD (-3) b=5 SHALL give HI=0xFFFFFFFF and LO=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7) b=2 SHALL give LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-039 DIVU a=0x12345678 b=0 SHALL give LO=0xFFFFFFFF and HI=0x12345678; DIV 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-040 MTHI a=0xCAFEF00D, then op=110 SHALL give result=0xCAFEF00D the next cycle with busy=0 throughout; MTLO followed by MFLO SHALL behave likewise.
REQ-041 A start with MULTU 7*9 at RUN iteration 5 of an in-flight DIVU 100/7 SHALL be ignored, and the DIVU SHALL finish with LO=14 and HI=2.
REQ-042 Reset at RUN iteration 10 of MULT SHALL give hi=0, lo=0, busy=0 and no done; a new MULTU 6*7 SHALL then complete with LO=42 and HI=0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: HI/LO op encoding and the multiply/divide FSM state type.
// Also imported by the ALU control decoder.
package mips_cpu_pkg;

   typedef enum logic [2:0] {
      OP_DIVU  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_MULT  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_MFHI  = 3'b110,
      OP_MFLO  = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic logic is_div_op(input md_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input md_op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mips_cpu_mult_div.sv
// Iterative radix-2 HI/LO unit: shift-add multiply and restoring divide on magnitudes,
// sharing one 2*WIDTH accumulator and one adder/subtractor, with sign fix-up in FIX.
module mips_cpu_mult_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   import mips_cpu_pkg::*;

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   md_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic                 div_q, div_d;
   logic                 neg_lo_q, neg_lo_d;
   logic                 neg_hi_q, neg_hi_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;

   md_op_e               op_sel;
   logic                 sign_a, sign_b;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       add_x, add_y;
   logic [WIDTH+1:0]     add_res;
   logic [2*WIDTH-1:0]   step_acc;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix;

   assign op_sel = md_op_e'(op);
   assign sign_a = is_signed_op(op_sel) & a[WIDTH-1];
   assign sign_b = is_signed_op(op_sel) & b[WIDTH-1];
   assign mag_a  = sign_a ? (~a + 1'b1) : a;
   assign mag_b  = sign_b ? (~b + 1'b1) : b;

   // Multiply adds the multiplicand to the upper half; divide subtracts the divisor
   // from the upper half shifted left by one, so bit WIDTH+1 is the borrow.
   assign add_x   = div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
   assign add_y   = {1'b0, mcand_q};
   assign add_res = div_q ? ({1'b0, add_x} - {1'b0, add_y}) : ({1'b0, add_x} + {1'b0, add_y});

   always_comb begin
      step_acc = {1'b0, acc_q[2*WIDTH-1:1]};
      if (div_q) begin
         if (add_res[WIDTH+1]) step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
         else                  step_acc = {add_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else if (acc_q[0]) begin
         step_acc = {add_res[WIDTH:0], acc_q[WIDTH-1:1]};
      end
   end

   assign prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
   assign quot_fix = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op_sel)
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  OP_MFHI, OP_MFLO: ;
                  default: begin
                     state_d  = ST_RUN;
                     cnt_d    = '0;
                     acc_d    = {{WIDTH{1'b0}}, mag_a};
                     mcand_d  = mag_b;
                     div_d    = is_div_op(op_sel);
                     // A zero divisor keeps the all-ones quotient unsigned-looking.
                     neg_lo_d = (sign_a ^ sign_b) & ~(is_div_op(op_sel) & (b == '0));
                     neg_hi_d = sign_a;
                  end
               endcase
            end
         end
         ST_RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) state_d = ST_FIX;
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (div_q) begin
               lo_d = quot_fix;
               hi_d = rem_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         div_q    <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign result = (op_sel == OP_MFHI) ? hi_q :
                   (op_sel == OP_MFLO) ? lo_q : '0;

endmodule
